// File: rtl/gps_ca_pkg.sv
// Shared constants for the GPS C/A code generator: code geometry,
// G1/G2 initial fill and the per-PRN G2 phase-selector tap pairs.
package gps_ca_pkg;

    localparam int CHIPS_PER_CODE = 1023;
    localparam int MS_PER_BIT     = 20;
    localparam int MAX_PRN        = 36;

    // Both LFSRs start (and restart at each code epoch) from all ones.
    localparam logic [9:0] G_INIT = 10'h3FF;

    // G2 stage pairs whose XOR sets the code phase of PRN 1..36 (index = PRN-1).
    localparam int G2_TAP_A [0:MAX_PRN-1] = '{
        2, 3, 4, 5, 1, 2, 1, 2, 3, 2, 3, 5, 6, 7, 8, 9, 1, 2,
        3, 4, 5, 6, 1, 4, 5, 6, 7, 8, 1, 2, 3, 4, 5, 4, 1, 2
    };
    localparam int G2_TAP_B [0:MAX_PRN-1] = '{
        6, 7, 8, 9, 9, 10, 8, 9, 10, 3, 4, 6, 7, 8, 9, 10, 4, 5,
        6, 7, 8, 9, 3, 6, 7, 8, 9, 10, 6, 7, 8, 9, 10, 10, 7, 8
    };

endpackage

// File: rtl/code_nco.sv
// Code-rate phase accumulator. carry marks the cycle whose edge starts a
// new chip; it is already qualified by enable so the caller can use it directly.
module code_nco #(
    parameter int PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               sync,
    input  logic [PHASE_W-1:0] code_freq,
    output logic               carry
);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W:0]   sum;

    assign sum   = {1'b0, phase} + {1'b0, code_freq};
    assign carry = enable & sum[PHASE_W];

    // Accumulate while enabled; sync restarts the phase from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (enable) begin
            if (sync) begin
                phase <= '0;
            end else begin
                phase <= sum[PHASE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ca_code_gen.sv
// Chip-rate NCO plus parallel GPS C/A Gold-code generator with chip,
// 1 ms epoch and 20 ms nav-bit strobes. ca_seq bit i carries PRN i+1.
module ca_code_gen
    import gps_ca_pkg::*;
#(
    parameter int NUM_PRN = 36,
    parameter int PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PHASE_W-1:0] code_freq,
    input  logic               sync,
    output logic [NUM_PRN-1:0] ca_seq,
    output logic               chip_strobe,
    output logic [9:0]         chip_count,
    output logic               epoch,
    output logic [4:0]         ms_count,
    output logic               bit_edge
);

    localparam logic [9:0] LAST_CHIP = 10'(CHIPS_PER_CODE - 1);
    localparam logic [4:0] LAST_MS   = 5'(MS_PER_BIT - 1);

    logic               carry;
    logic               advance;
    logic               restart;
    logic               wrap;
    logic               last_ms;
    logic [10:1]        g1_q;
    logic [10:1]        g2_q;
    logic [10:1]        g1_n;
    logic [10:1]        g2_n;
    logic [NUM_PRN-1:0] ca_seq_n;

    code_nco #(
        .PHASE_W   (PHASE_W)
    ) u_nco (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sync      (sync),
        .code_freq (code_freq),
        .carry     (carry)
    );

    // sync takes priority over a chip advance landing on the same edge.
    assign restart = enable & sync;
    assign advance = carry & ~sync;
    assign wrap    = (chip_count == LAST_CHIP);
    assign last_ms = (ms_count == LAST_MS);

    // Next LFSR contents: shift on advance, reload at code wrap or restart.
    always_comb begin
        g1_n = g1_q;
        g2_n = g2_q;
        if (restart) begin
            g1_n = G_INIT;
            g2_n = G_INIT;
        end else if (advance) begin
            if (wrap) begin
                // The LFSRs are back at all ones here anyway; reloading keeps them locked to chip 0.
                g1_n = G_INIT;
                g2_n = G_INIT;
            end else begin
                g1_n = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
                g2_n = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
            end
        end
    end

    // Chip values come from the next-state LFSRs so ca_seq changes on the advance edge.
    for (genvar i = 0; i < NUM_PRN; i++) begin : g_prn
        assign ca_seq_n[i] = g1_n[10] ^ g2_n[G2_TAP_A[i]] ^ g2_n[G2_TAP_B[i]];
    end

    // LFSRs and code output register; frozen while enable is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            g1_q   <= G_INIT;
            g2_q   <= G_INIT;
            ca_seq <= '1;
        end else if (enable) begin
            g1_q   <= g1_n;
            g2_q   <= g2_n;
            ca_seq <= ca_seq_n;
        end
    end

    // Chip and millisecond counters step together with the code.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            chip_count <= '0;
            ms_count   <= '0;
        end else if (advance) begin
            if (wrap) begin
                chip_count <= '0;
                ms_count   <= last_ms ? 5'd0 : ms_count + 5'd1;
            end else begin
                chip_count <= chip_count + 10'd1;
            end
        end
    end

    // Strobes are single-cycle pulses tied to the edge that applied an advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            chip_strobe <= 1'b0;
            epoch       <= 1'b0;
            bit_edge    <= 1'b0;
        end else begin
            chip_strobe <= advance;
            epoch       <= advance & wrap;
            bit_edge    <= advance & wrap & last_ms;
        end
    end

endmodule

// File: tb/tb_ca_code_gen.sv
// Bench for ca_code_gen: a cycle model built from the NCO/counter rules plus
// Gold-code tables derived from the G1/G2 polynomials as bit sequences.
module tb_ca_code_gen;

    localparam int NUM_PRN = 36;
    localparam int PHASE_W = 32;
    localparam int W       = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               sync = 1'b0;
    logic [PHASE_W-1:0] code_freq = '0;
    logic [NUM_PRN-1:0] ca_seq;
    logic               chip_strobe;
    logic [9:0]         chip_count;
    logic               epoch;
    logic [4:0]         ms_count;
    logic               bit_edge;

    ca_code_gen #(
        .NUM_PRN     (NUM_PRN),
        .PHASE_W     (PHASE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .code_freq   (code_freq),
        .sync        (sync),
        .ca_seq      (ca_seq),
        .chip_strobe (chip_strobe),
        .chip_count  (chip_count),
        .epoch       (epoch),
        .ms_count    (ms_count),
        .bit_edge    (bit_edge)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference Gold-code tables ----------------
    int ta [0:35] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4,5,4,1,2};
    int tb [0:35] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9,10,10,7,8};
    logic [NUM_PRN-1:0] gold [0:1022];

    // Stage j at chip n holds output-sequence bit n+10-j; all-ones fill gives a[0..9]=1.
    task automatic build_gold();
        bit a1 [0:1032];
        bit a2 [0:1032];
        for (int n = 0; n < 10; n++) begin
            a1[n] = 1'b1;
            a2[n] = 1'b1;
        end
        for (int n = 0; n + 10 <= 1032; n++) begin
            a1[n+10] = a1[n+7] ^ a1[n];
            a2[n+10] = a2[n+8] ^ a2[n+7] ^ a2[n+4] ^ a2[n+2] ^ a2[n+1] ^ a2[n];
        end
        for (int k = 0; k < 1023; k++) begin
            for (int i = 0; i < NUM_PRN; i++) begin
                gold[k][i] = a1[k] ^ a2[k+10-ta[i]] ^ a2[k+10-tb[i]];
            end
        end
    endtask

    // ---------------- cycle model ----------------
    logic [31:0] m_phase = '0;
    int          m_chip = 0;
    int          m_ms = 0;
    bit          m_cs, m_ep, m_be;
    int          cycle = 0;
    int          n_strobe = 0;
    int          n_bitedge = 0;
    int          last_strobe = 0;
    int          gap = 0;
    bit          chk_consec = 1'b0;
    bit          prev_cs = 1'b0;

    // One clock: update the model from the inputs seen at the edge, then compare.
    task automatic tick();
        logic [32:0] s;
        @(posedge clk);
        s = {1'b0, m_phase} + {1'b0, code_freq};
        m_cs = 1'b0;
        m_ep = 1'b0;
        m_be = 1'b0;
        if (rst) begin
            m_phase = '0;
            m_chip  = 0;
            m_ms    = 0;
        end else if (enable) begin
            if (sync) begin
                m_phase = '0;
                m_chip  = 0;
                m_ms    = 0;
            end else begin
                m_phase = s[31:0];
                if (s[32]) begin
                    m_cs = 1'b1;
                    if (m_chip == 1022) begin
                        m_chip = 0;
                        m_ep   = 1'b1;
                        if (m_ms == 19) begin
                            m_ms = 0;
                            m_be = 1'b1;
                        end else begin
                            m_ms++;
                        end
                    end else begin
                        m_chip++;
                    end
                end
            end
        end
        #1;
        cycle++;
        check("ca_seq", ca_seq, gold[m_chip]);
        check("chip_count", chip_count, m_chip);
        check("ms_count", ms_count, m_ms);
        check("chip_strobe", chip_strobe, m_cs);
        check("epoch", epoch, m_ep);
        check("bit_edge", bit_edge, m_be);
        if (chk_consec) check("no_consec_strobe", prev_cs & chip_strobe, 0);
        prev_cs = chip_strobe;
        if (chip_strobe) begin
            n_strobe++;
            gap = cycle - last_strobe;
            last_strobe = cycle;
        end
        if (bit_edge) n_bitedge++;
    endtask

    task automatic wait_strobe(input int budget, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!chip_strobe && n < budget);
        if (!chip_strobe) check(tag, chip_strobe, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sync = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [9:0] oct [0:3] = '{10'o1440, 10'o1620, 10'o1710, 10'o1744};
    bit         obs1 [0:1022];
    bit         obs2 [0:1022];
    int         ones [0:NUM_PRN-1];

    initial begin
        int k, chip, per, mism, s0, n;
        logic [W-1:0] v;
        bit first;
        build_gold();

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("reset_ca_seq", ca_seq, {NUM_PRN{1'b1}});
        check("reset_chip_count", chip_count, 0);
        check("reset_strobe", chip_strobe, 0);
        rst = 1'b0;
        enable = 1'b1;
        code_freq = 32'h8000_0000;

        // First ten chips of PRN 1..4 against the published octal words
        for (int c = 0; c < 10; c++) begin
            for (int p = 0; p < W; p++) v[p] = oct[p][9-c];
            exp_q.push_back(v);
        end
        for (int p = 0; p < NUM_PRN; p++) ones[p] = ca_seq[p];
        obs1[0] = ca_seq[0];
        check("first10_chip0", ca_seq[W-1:0], exp_q.pop_front());

        // 20 code periods at half clock rate
        n_bitedge = 0;
        for (k = 1; k <= 20 * 1023; k++) begin
            wait_strobe(4, "strobe_timeout");
            chip = k % 1023;
            per  = k / 1023;
            if (k < 10) check("first10", ca_seq[W-1:0], exp_q.pop_front());
            if (k >= 2) check("strobe_gap", gap, 2);
            check("epoch_at_wrap", epoch, (chip == 0));
            if (chip == 0) begin
                check("epoch_g1", dut.g1_q, 10'h3FF);
                check("epoch_g2", dut.g2_q, 10'h3FF);
                check("epoch_ca_ones", ca_seq, {NUM_PRN{1'b1}});
                check("epoch_ms_count", ms_count, per % 20);
            end
            if (per == 0) begin
                obs1[chip] = ca_seq[0];
                for (int p = 0; p < NUM_PRN; p++) ones[p] += ca_seq[p];
            end else if (per == 1) begin
                obs2[chip] = ca_seq[0];
            end
        end
        check("bit_edge_count", n_bitedge, 1);
        check("bit_edge_ms_zero", ms_count, 0);
        mism = 0;
        for (int c = 0; c < 1023; c++) if (obs1[c] != obs2[c]) mism++;
        check("prn1_repeat", mism, 0);
        for (int p = 0; p < NUM_PRN; p++) check("ones_per_period", ones[p], 512);

        // Random rate, enable and sync
        chk_consec = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 63) == 0) code_freq = $urandom_range(0, 32'h8000_0000);
            enable = ($urandom_range(0, 7) != 0);
            sync   = ($urandom_range(0, 199) == 0);
            tick();
        end
        chk_consec = 1'b0;
        sync = 1'b0;
        enable = 1'b1;

        // Zero rate holds everything, then quarter rate strobes on the 4th edge
        do_reset();
        code_freq = '0;
        tick();
        s0 = n_strobe;
        repeat (1000) tick();
        check("freq0_strobes", n_strobe - s0, 0);
        check("freq0_ca_seq", ca_seq, {NUM_PRN{1'b1}});
        code_freq = 32'h4000_0000;
        do_reset();
        code_freq = 32'h4000_0000;
        n = 0;
        do begin
            tick();
            n++;
        end while (!chip_strobe && n < 10);
        check("first_strobe_cycle", n, 4);

        // Sync on the edge that would advance from chip 500
        do_reset();
        code_freq = 32'h8000_0000;
        for (int c = 0; c < 500; c++) wait_strobe(4, "strobe_timeout_sync");
        check("pre_sync_chip", chip_count, 500);
        tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_chip_count", chip_count, 0);
        check("sync_ms_count", ms_count, 0);
        check("sync_ca_seq", ca_seq, {NUM_PRN{1'b1}});
        check("sync_strobe", chip_strobe, 0);

        // enable toggling every cycle quarters the strobe rate
        do_reset();
        code_freq = 32'h8000_0000;
        first = 1'b1;
        for (int c = 0; c < 48; c++) begin
            enable = (c % 2 == 0);
            tick();
            if (chip_strobe) begin
                if (!first) check("toggle_gap", gap, 4);
                first = 1'b0;
            end
        end
        enable = 1'b1;
        repeat (31) tick();
        rst = 1'b1;
        sync = 1'b1;
        tick();
        rst = 1'b0;
        sync = 1'b0;
        check("midrst_chip_count", chip_count, 0);
        check("midrst_ca_seq", ca_seq, {NUM_PRN{1'b1}});
        check("midrst_strobe", chip_strobe, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
